// File: rtl/seg7_int_driver_n.sv
// Signed/unsigned binary to N-digit multiplexed 7-seg driver, double-dabble.
// Define SEG7_FLOAT_SIGN_EN to float the minus sign next to the leading digit.
module seg7_int_driver_n #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4,
  parameter int SIGNED = 1
) (
  input  logic              clk_1000hz,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  bin_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o,
  output logic              busy_o,
  output logic              ovf_o
);

  localparam int MAGD = (SIGNED != 0) ? DIGITS - 1 : DIGITS;
  localparam int BW   = 4 * DIGITS;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_MAG = pow10(MAGD) - 64'd1;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = BLANK;
    endcase
    return c;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [WIDTH-1:0] mag;
  logic             neg_r;
  logic             ovf_r;
  logic             neg_in;
  logic [WIDTH-1:0] mag_in;
  logic [6:0]       disp [DIGITS];
  logic [6:0]       nxt  [DIGITS];
  logic [IW-1:0]    idx;
  int               msd;

  assign neg_in = (SIGNED != 0) && bin_i[WIDTH-1];
  assign mag_in = neg_in ? (~bin_i + 1'b1) : bin_i;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Highest non-zero magnitude digit; zero still shows a '0' on digit 0
  always_comb begin
    msd = 0;
    for (int i = 0; i < MAGD; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      nxt[i] = BLANK;
      if (i < MAGD && i <= msd) nxt[i] = seg_code(bcd[4*i +: 4]);
`ifdef SEG7_FLOAT_SIGN_EN
      if (neg_r && i == msd + 1) nxt[i] = MINUS;
`else
      if (neg_r && i == DIGITS - 1) nxt[i] = MINUS;
`endif
      if (ovf_r) nxt[i] = MINUS;
    end
  end

  always_ff @(posedge clk_1000hz or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      bcd    <= '0;
      mag    <= '0;
      neg_r  <= 1'b0;
      ovf_r  <= 1'b0;
      busy_o <= 1'b0;
      ovf_o  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          mag    <= mag_in;
          neg_r  <= neg_in;
          ovf_r  <= 64'(mag_in) > MAX_MAG;
          bcd    <= '0;
          cnt    <= CW'(WIDTH - 1);
          busy_o <= 1'b1;
          state  <= SHIFT;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
          if (cnt == '0) state <= UPDATE;
          else cnt <= cnt - 1'b1;
        end
        UPDATE: begin
          for (int i = 0; i < DIGITS; i++) disp[i] <= nxt[i];
          ovf_o  <= ovf_r;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1000hz or negedge rst_i) begin
    if (!rst_i) begin
      idx   <= '0;
      an_o  <= '1;
      seg_o <= BLANK;
    end else begin
      an_o  <= ~(DIGITS'(1) << idx);
      seg_o <= disp[idx];
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_int_driver_n.sv
// Directed bench for seg7_int_driver_n: an 8-bit and a 12-bit instance
// share one clock and reset; frames are rebuilt from the scanned pins.
module tb_seg7_int_driver_n;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  bin8 = '0;
  logic [11:0] bin12 = '0;
  logic [3:0]  an8, an12;
  logic [6:0]  seg8, seg12;
  logic        busy8, busy12, ovf8, ovf12;

  int vecs = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_int_driver_n #(.WIDTH(8), .DIGITS(4), .SIGNED(1)) u8 (
    .clk_1000hz(clk),
    .rst_i(rst),
    .bin_i(bin8),
    .an_o(an8),
    .seg_o(seg8),
    .busy_o(busy8),
    .ovf_o(ovf8)
  );

  seg7_int_driver_n #(.WIDTH(12), .DIGITS(4), .SIGNED(1)) u12 (
    .clk_1000hz(clk),
    .rst_i(rst),
    .bin_i(bin12),
    .an_o(an12),
    .seg_o(seg12),
    .busy_o(busy12),
    .ovf_o(ovf12)
  );

  typedef struct {
    string       name;
    bit          wide;
    logic [11:0] bin;
    logic [27:0] frm;
    logic        ovf;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic grab(input bit wide, output logic [27:0] f);
    logic [3:0] a;
    logic [6:0] s;
    f = 'x;
    repeat (4) begin
      @(negedge clk);
      a = wide ? an12 : an8;
      s = wide ? seg12 : seg8;
      for (int k = 0; k < 4; k++) begin
        if (a == ~(4'b0001 << k)) f[7*k +: 7] = s;
      end
    end
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy8 !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_wait", 32'(busy8), 32'(lvl));
  endtask

  initial begin
    logic [27:0] f;
    int n;

    tv[0]  = '{"zero",    1'b0, 12'h000, {BL, BL, BL, C0}, 1'b0};
    tv[1]  = '{"m128",    1'b0, 12'h080, {MI, C1, C2, C8}, 1'b0};
`ifdef SEG7_FLOAT_SIGN_EN
    tv[2]  = '{"m5",      1'b0, 12'h0FB, {BL, BL, MI, C5}, 1'b0};
    tv[3]  = '{"m1",      1'b0, 12'h0FF, {BL, BL, MI, C1}, 1'b0};
    tv[4]  = '{"m99",     1'b0, 12'h09D, {BL, MI, C9, C9}, 1'b0};
`else
    tv[2]  = '{"m5",      1'b0, 12'h0FB, {MI, BL, BL, C5}, 1'b0};
    tv[3]  = '{"m1",      1'b0, 12'h0FF, {MI, BL, BL, C1}, 1'b0};
    tv[4]  = '{"m99",     1'b0, 12'h09D, {MI, BL, C9, C9}, 1'b0};
`endif
    tv[5]  = '{"p42",     1'b0, 12'h02A, {BL, BL, C4, C2}, 1'b0};
    tv[6]  = '{"p127",    1'b0, 12'h07F, {BL, C1, C2, C7}, 1'b0};
    tv[7]  = '{"p100",    1'b0, 12'h064, {BL, C1, C0, C0}, 1'b0};
    tv[8]  = '{"w1000",   1'b1, 12'd1000, {MI, MI, MI, MI}, 1'b1};
    tv[9]  = '{"w999",    1'b1, 12'd999,  {BL, C9, C9, C9}, 1'b0};
    tv[10] = '{"wm999",   1'b1, 12'hC19,  {MI, C9, C9, C9}, 1'b0};
    tv[11] = '{"wm1000",  1'b1, 12'hC18,  {MI, MI, MI, MI}, 1'b1};
    tv[12] = '{"wm2048",  1'b1, 12'h800,  {MI, MI, MI, MI}, 1'b1};
    tv[13] = '{"w7",      1'b1, 12'd7,    {BL, BL, BL, C7}, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an8), 32'hF);
    chk("rst_seg", 32'(seg8), 32'(BL));
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_an12", 32'(an12), 32'hF);

    rst = 1'b1;
    @(negedge clk);
    chk("first_an", 32'(an8), 32'hE);
    chk("first_busy", 32'(busy8), 32'd1);
    n = 1;
    @(negedge clk);
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 32'd9);

    for (int i = 0; i < 14; i++) begin
      if (tv[i].wide) bin12 = tv[i].bin;
      else bin8 = tv[i].bin[7:0];
      repeat (32) @(negedge clk);
      grab(tv[i].wide, f);
      chk({tv[i].name, "_frm"}, 32'(f), 32'(tv[i].frm));
      chk({tv[i].name, "_ovf"}, 32'(tv[i].wide ? ovf12 : ovf8),
          32'(tv[i].ovf));
    end

    bin8 = 8'd42;
    repeat (32) @(negedge clk);
    grab(1'b0, f);
    chk("hold42_a", 32'(f), 32'({BL, BL, C4, C2}));
    wait_busy(1'b0);
    wait_busy(1'b1);
    repeat (2) @(negedge clk);
    bin8 = 8'd17;
    grab(1'b0, f);
    chk("hold42_b", 32'(f), 32'({BL, BL, C4, C2}));
    wait_busy(1'b0);
    grab(1'b0, f);
    chk("hold42_c", 32'(f), 32'({BL, BL, C4, C2}));
    repeat (24) @(negedge clk);
    grab(1'b0, f);
    chk("show17", 32'(f), 32'({BL, BL, C1, C7}));

    wait_busy(1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an8), 32'hF);
    chk("mid_rst_seg", 32'(seg8), 32'(BL));
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    grab(1'b0, f);
    chk("post_rst_blank", 32'(f), 32'h0FFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
